// File: rtl/jtag_tap_controller_if.sv
// JTAG pin bundle between the host-side driver and the target TAP.
// The host owns tck/tms/tdi/trst; the target drives tdo back.
interface jtag_interface;
    logic tck;
    logic tms;
    logic tdi;
    logic trst;
    logic tdo;

    modport master (output tck, tms, tdi, trst, input tdo);
    modport slave  (input tck, tms, tdi, trst, output tdo);
endinterface

// File: rtl/jtag_tap_controller.sv
// Target-side IEEE 1149.1 TAP: oversamples the JTAG pins in the clk domain,
// runs the 16-state TAP FSM and owns IR, IDCODE, bypass and user DR chains.
module jtag_tap_controller #(
    parameter int          INSTRUCTION_WIDTH = 4,
    parameter int          DATA_WIDTH        = 32,
    parameter logic [31:0] JTAG_ID           = 32'h4E595A49
) (
    input  logic                         clk,
    input  logic                         reset,
    jtag_interface.slave                 jtag,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         capture_dr,
    output logic                         update_dr,
    output logic                         update_ir,
    output logic [DATA_WIDTH-1:0]        data_out
);

    localparam int IW = INSTRUCTION_WIDTH;
    localparam int DW = DATA_WIDTH;

    localparam logic [IW-1:0] IR_IDCODE = IW'(1);
    localparam logic [IW-1:0] IR_BYPASS = '1;

    localparam logic [3:0] S_TLR    = 4'hF;
    localparam logic [3:0] S_RTI    = 4'hC;
    localparam logic [3:0] S_SEL_DR = 4'h7;
    localparam logic [3:0] S_CAP_DR = 4'h6;
    localparam logic [3:0] S_SH_DR  = 4'h2;
    localparam logic [3:0] S_EX1_DR = 4'h1;
    localparam logic [3:0] S_PAU_DR = 4'h3;
    localparam logic [3:0] S_EX2_DR = 4'h0;
    localparam logic [3:0] S_UPD_DR = 4'h5;
    localparam logic [3:0] S_SEL_IR = 4'h4;
    localparam logic [3:0] S_CAP_IR = 4'hE;
    localparam logic [3:0] S_SH_IR  = 4'hA;
    localparam logic [3:0] S_EX1_IR = 4'h9;
    localparam logic [3:0] S_PAU_IR = 4'hB;
    localparam logic [3:0] S_EX2_IR = 4'h8;
    localparam logic [3:0] S_UPD_IR = 4'hD;

    logic r_tck_s1, r_tck_s2, r_tck_prev;
    logic r_tms_s1, r_tms_s2;
    logic r_tdi_s1, r_tdi_s2;
    logic r_trst_s1, r_trst_s2;

    logic [3:0]    r_state;
    logic [3:0]    w_state_next;
    logic [IW-1:0] r_instruction;
    logic [IW-1:0] r_ir_shift;
    logic [31:0]   r_id_shift;
    logic [DW-1:0] r_dr_shift;
    logic          r_bypass;
    logic          r_tdo;
    logic          r_capture_dr;
    logic          r_update_dr;
    logic          r_update_ir;
    logic [DW-1:0] r_data_out;

    logic w_tck_rise;
    logic w_tck_fall;
    logic w_is_idcode;
    logic w_is_bypass;
    logic w_is_user;

    assign w_tck_rise  = r_tck_s2 & ~r_tck_prev;
    assign w_tck_fall  = ~r_tck_s2 & r_tck_prev;
    assign w_is_idcode = (r_instruction == IR_IDCODE);
    assign w_is_bypass = (r_instruction == IR_BYPASS);
    assign w_is_user   = ~w_is_idcode & ~w_is_bypass;

    assign instruction = r_instruction;
    assign capture_dr  = r_capture_dr;
    assign update_dr   = r_update_dr;
    assign update_ir   = r_update_ir;
    assign data_out    = r_data_out;
    assign jtag.tdo    = r_tdo;

    // Two-flop synchronizers on every pin, plus a history flop for tck edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tck_s1   <= 1'b0;
            r_tck_s2   <= 1'b0;
            r_tck_prev <= 1'b0;
            r_tms_s1   <= 1'b0;
            r_tms_s2   <= 1'b0;
            r_tdi_s1   <= 1'b0;
            r_tdi_s2   <= 1'b0;
            r_trst_s1  <= 1'b0;
            r_trst_s2  <= 1'b0;
        end else begin
            r_tck_s1   <= jtag.tck;
            r_tck_s2   <= r_tck_s1;
            r_tck_prev <= r_tck_s2;
            r_tms_s1   <= jtag.tms;
            r_tms_s2   <= r_tms_s1;
            r_tdi_s1   <= jtag.tdi;
            r_tdi_s2   <= r_tdi_s1;
            r_trst_s1  <= jtag.trst;
            r_trst_s2  <= r_trst_s1;
        end
    end

    // 1149.1 next-state table driven by the synchronized tms.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_TLR:    w_state_next = r_tms_s2 ? S_TLR    : S_RTI;
            S_RTI:    w_state_next = r_tms_s2 ? S_SEL_DR : S_RTI;
            S_SEL_DR: w_state_next = r_tms_s2 ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: w_state_next = r_tms_s2 ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  w_state_next = r_tms_s2 ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: w_state_next = r_tms_s2 ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: w_state_next = r_tms_s2 ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: w_state_next = r_tms_s2 ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: w_state_next = r_tms_s2 ? S_SEL_DR : S_RTI;
            S_SEL_IR: w_state_next = r_tms_s2 ? S_TLR    : S_CAP_IR;
            S_CAP_IR: w_state_next = r_tms_s2 ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  w_state_next = r_tms_s2 ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: w_state_next = r_tms_s2 ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: w_state_next = r_tms_s2 ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: w_state_next = r_tms_s2 ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: w_state_next = r_tms_s2 ? S_SEL_DR : S_RTI;
            default:  w_state_next = S_TLR;
        endcase
    end

    // State register, instruction register and the one-clk event pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_TLR;
            r_instruction <= IR_IDCODE;
            r_capture_dr  <= 1'b0;
            r_update_dr   <= 1'b0;
            r_update_ir   <= 1'b0;
            r_data_out    <= '0;
        end else begin
            r_capture_dr <= 1'b0;
            r_update_dr  <= 1'b0;
            r_update_ir  <= 1'b0;
            if (r_trst_s2) begin
                r_state       <= S_TLR;
                r_instruction <= IR_IDCODE;
            end else if (w_tck_rise) begin
                r_state <= w_state_next;
                if (r_state == S_CAP_DR && w_is_user) begin
                    r_capture_dr <= 1'b1;
                end
                if (w_state_next == S_UPD_IR) begin
                    r_instruction <= r_ir_shift;
                    r_update_ir   <= 1'b1;
                end else if (w_state_next == S_TLR) begin
                    r_instruction <= IR_IDCODE;
                end
                if (w_state_next == S_UPD_DR && w_is_user) begin
                    r_data_out  <= r_dr_shift;
                    r_update_dr <= 1'b1;
                end
            end else if (r_state == S_TLR) begin
                r_instruction <= IR_IDCODE;
            end
        end
    end

    // Capture and shift of the IR and the DR chain selected by the instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir_shift <= '0;
            r_id_shift <= '0;
            r_dr_shift <= '0;
            r_bypass   <= 1'b0;
        end else if (w_tck_rise && !r_trst_s2) begin
            case (r_state)
                S_CAP_IR: r_ir_shift <= IW'(1);
                S_SH_IR:  r_ir_shift <= {r_tdi_s2, r_ir_shift[IW-1:1]};
                S_CAP_DR: begin
                    if (w_is_idcode)      r_id_shift <= JTAG_ID;
                    else if (w_is_bypass) r_bypass   <= 1'b0;
                    else                  r_dr_shift <= data_in;
                end
                S_SH_DR: begin
                    if (w_is_idcode)
                        r_id_shift <= {r_tdi_s2, r_id_shift[31:1]};
                    else if (w_is_bypass)
                        r_bypass <= r_tdi_s2;
                    else
                        r_dr_shift <= {r_tdi_s2, r_dr_shift[DW-1:1]};
                end
                default: ;
            endcase
        end
    end

    // tdo launches on the falling tck edge so the host sees it at the next rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tdo <= 1'b0;
        end else if (w_tck_fall) begin
            if (r_state == S_SH_IR)
                r_tdo <= r_ir_shift[0];
            else if (r_state == S_SH_DR)
                r_tdo <= w_is_idcode ? r_id_shift[0] :
                         w_is_bypass ? r_bypass : r_dr_shift[0];
            else
                r_tdo <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Randomized bench for jtag_tap_controller: a host driver plus a scan-level
// model that predicts tdo streams, instruction, data_out and pulse counts.
module tb_jtag_tap_controller;

    localparam int          IW = 4;
    localparam int          DW = 32;
    localparam logic [31:0] ID = 32'h4E595A49;

    localparam logic [IW-1:0] IR_ID  = IW'(1);
    localparam logic [IW-1:0] IR_BYP = '1;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic [IW-1:0] instruction;
    logic          capture_dr;
    logic          update_dr;
    logic          update_ir;
    logic [DW-1:0] data_out;

    jtag_interface jtag();

    jtag_tap_controller #(
        .INSTRUCTION_WIDTH(IW),
        .DATA_WIDTH(DW),
        .JTAG_ID(ID)
    ) dut (
        .clk(clk),
        .reset(reset),
        .jtag(jtag),
        .data_in(data_in),
        .instruction(instruction),
        .capture_dr(capture_dr),
        .update_dr(update_dr),
        .update_ir(update_ir),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_cap = 0;
    int n_upd = 0;
    int n_uir = 0;
    int e_cap = 0;
    int e_upd = 0;
    int e_uir = 0;

    logic [IW-1:0] exp_instr = IR_ID;
    logic [DW-1:0] exp_dout  = '0;

    // Pulse monitor: every high cycle of a pulse output is one event.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (capture_dr) n_cap++;
            if (update_dr)  n_upd++;
            if (update_ir)  n_uir++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // One tck period: 8 clk low (tdo sampled at the end), 8 clk high.
    task automatic tck_cycle(input logic tms, input logic tdi,
                             output logic tdo);
        jtag.tms = tms;
        jtag.tdi = tdi;
        wait_clks(8);
        tdo = jtag.tdo;
        jtag.tck = 1'b1;
        wait_clks(8);
        jtag.tck = 1'b0;
    endtask

    task automatic shift_bits(input int n, input logic [63:0] tdi_v,
                              output logic [63:0] tdo_v);
        logic b;
        tdo_v = '0;
        for (int k = 0; k < n; k++) begin
            tck_cycle(k == n - 1, tdi_v[k], b);
            tdo_v[k] = b;
        end
    endtask

    // Full IR scan from Run-Test/Idle back to Run-Test/Idle.
    task automatic ir_scan(input logic [IW-1:0] val);
        logic [63:0] tdo_v;
        logic b;
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        shift_bits(IW, 64'(val), tdo_v);
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        wait_clks(2);
        exp_instr = val;
        e_uir++;
        check("ir.tdo", tdo_v, 64'h1);
        check("ir.instr", 64'(instruction), 64'(exp_instr));
        check("ir.upd", 64'(n_uir), 64'(e_uir));
    endtask

    // Full DR scan; the selected chain's capture value followed by the
    // shifted-in bits form one stream that tdo and data_out are cut from.
    task automatic dr_scan(input string tag, input int n,
                           input logic [63:0] tdi_raw,
                           input logic [DW-1:0] din);
        logic [63:0] tdo_v, stream, mask, tdi_v;
        int len;
        logic b;
        bit user;
        mask  = (64'h1 << n) - 64'h1;
        tdi_v = tdi_raw & mask;
        data_in = din;
        user = 1'b0;
        if (exp_instr == IR_ID) begin
            len = 32;
            stream = {32'h0, ID};
        end else if (exp_instr == IR_BYP) begin
            len = 1;
            stream = 64'h0;
        end else begin
            len = DW;
            stream = 64'(din);
            user = 1'b1;
        end
        stream = stream | (tdi_v << len);
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        shift_bits(n, tdi_v, tdo_v);
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        wait_clks(2);
        if (user) begin
            exp_dout = DW'(stream >> n);
            e_cap++;
            e_upd++;
        end
        check({tag, ".tdo"}, tdo_v, stream & mask);
        check({tag, ".dout"}, 64'(data_out), 64'(exp_dout));
        check({tag, ".cap"}, 64'(n_cap), 64'(e_cap));
        check({tag, ".upd"}, 64'(n_upd), 64'(e_upd));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic b;
        logic t0;
        logic [DW-1:0] din;
        logic [IW-1:0] ins;

        jtag.tck  = 1'b0;
        jtag.tms  = 1'b1;
        jtag.tdi  = 1'b0;
        jtag.trst = 1'b0;
        data_in   = '0;
        reset     = 1'b0;
        wait_clks(3);
        check("rst.instr", 64'(instruction), 64'(IR_ID));
        check("rst.dout", 64'(data_out), 64'h0);
        check("rst.tdo", 64'(jtag.tdo), 64'h0);
        check("rst.pulses", 64'({capture_dr, update_dr, update_ir}), 64'h0);
        reset = 1'b1;
        wait_clks(3);
        tck_cycle(1'b0, 1'b0, b);
        wait_clks(4);
        check("idle.pulses", 64'(n_cap + n_upd + n_uir), 64'h0);
        check("idle.instr", 64'(instruction), 64'(IR_ID));

        dr_scan("idcode", 32, 64'h0, $urandom);

        ir_scan(4'h3);
        dr_scan("user", 32, 64'h12345678, 32'hDEADBEEF);

        ir_scan(4'hF);
        dr_scan("bypass", 9, 64'h1A5, $urandom);

        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0:       ins = IR_ID;
                1:       ins = IR_BYP;
                default: ins = IW'($urandom);
            endcase
            ir_scan(ins);
            dr_scan("rand", 32, 64'($urandom), $urandom);
        end

        // Leave SHIFT_DR with five tms=1 clocks into Test-Logic-Reset.
        ir_scan(4'h3);
        din = $urandom;
        t0  = 1'($urandom);
        data_in = din;
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        e_cap++;
        tck_cycle(1'b1, t0, b);
        repeat (4) tck_cycle(1'b1, 1'b0, b);
        wait_clks(2);
        e_upd++;
        exp_dout  = {t0, din[DW-1:1]};
        exp_instr = IR_ID;
        check("tms5.instr", 64'(instruction), 64'(exp_instr));
        check("tms5.dout", 64'(data_out), 64'(exp_dout));
        check("tms5.upd", 64'(n_upd), 64'(e_upd));
        tck_cycle(1'b0, 1'b0, b);
        dr_scan("tms5.id", 32, 64'($urandom), $urandom);

        // trst pulse in the middle of an IR shift.
        ir_scan(4'h5);
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'($urandom), b);
        tck_cycle(1'b0, 1'($urandom), b);
        jtag.trst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_instr = IR_ID;
        check("trst.instr", 64'(instruction), 64'(exp_instr));
        wait_clks(2);
        jtag.trst = 1'b0;
        wait_clks(4);
        check("trst.uir", 64'(n_uir), 64'(e_uir));
        check("trst.hold", 64'(instruction), 64'(exp_instr));
        tck_cycle(1'b0, 1'b0, b);
        dr_scan("trst.id", 32, 64'h0, $urandom);

        // Asynchronous reset in the middle of a user DR shift.
        ir_scan(4'h3);
        data_in = $urandom;
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        e_cap++;
        repeat (5) tck_cycle(1'b0, 1'($urandom), b);
        reset = 1'b0;
        #1;
        exp_instr = IR_ID;
        exp_dout  = '0;
        check("arst.instr", 64'(instruction), 64'(exp_instr));
        check("arst.dout", 64'(data_out), 64'(exp_dout));
        check("arst.tdo", 64'(jtag.tdo), 64'h0);
        check("arst.pulses", 64'({capture_dr, update_dr, update_ir}), 64'h0);
        wait_clks(4);
        reset = 1'b1;
        wait_clks(4);
        check("arst.counts", 64'(n_cap + n_upd + n_uir),
              64'(e_cap + e_upd + e_uir));
        tck_cycle(1'b0, 1'b0, b);
        dr_scan("arst.id", 32, 64'h0, $urandom);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
